// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver.
// Glyphs are active-high and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD-to-glyph decoder; non-BCD codes 10..15 render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode display driver: one digit per refresh slot,
// per-frame snapshot of the BCD bus, leading-zero blanking and error dashes.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int               CNT_W    = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);
  localparam logic [3:0]       AN_IDLE  = {4{POL}};
  localparam logic [6:0]       SEG_IDLE = {7{POL}};
  localparam logic             DP_IDLE  = POL;

  logic [CNT_W-1:0]                cnt;
  logic                            tick;
  logic [1:0]                      idx;
  logic                            first;
  logic [NUM_DIGITS-1:0][3:0]      live_d;
  logic [NUM_DIGITS-1:0][3:0]      snap_d;
  logic [NUM_DIGITS-1:0][3:0]      src_d;
  logic [3:0]                      snap_dp;
  logic [3:0]                      src_dp;
  logic [NUM_DIGITS-1:0]           blank;
  logic                            zero_run;
  logic [3:0]                      cur;
  logic [6:0]                      glyph;
  logic [6:0]                      seg_h;

  assign live_d     = {digit3, digit2, digit1, digit0};
  assign tick       = en && (cnt == CNT_LAST);
  assign frame_done = tick && (idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // The bus is latched only at frame start (and right after reset) so a
  // counter update mid-frame can never mix old and new digits on the display.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first   <= 1'b1;
      snap_d  <= '0;
      snap_dp <= '0;
    end else begin
      first <= 1'b0;
      if (first || frame_done) begin
        snap_d  <= live_d;
        snap_dp <= dp_sel;
      end
    end
  end

  // The very first slot after reset reads the live bus, which is what the
  // snapshot is capturing on that same edge.
  assign src_d  = first ? live_d : snap_d;
  assign src_dp = first ? dp_sel : snap_dp;
  assign cur    = src_d[idx];

  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (src_d[i] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && zero_run;
    end
  end

  bcd_to_seg7 u_glyph (
    .bcd (cur),
    .seg (glyph)
  );

  assign seg_h = blank[idx] ? SEG_OFF : glyph;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= AN_IDLE;
      seg <= SEG_IDLE;
      dp  <= DP_IDLE;
    end else if (en) begin
      an  <= (4'b0001 << idx) ^ AN_IDLE;
      seg <= seg_h ^ SEG_IDLE;
      dp  <= src_dp[idx] ^ DP_IDLE;
    end else begin
      an  <= AN_IDLE;
      seg <= SEG_IDLE;
      dp  <= DP_IDLE;
    end
  end

endmodule
